// File: rtl/vp_pkg.sv
// vp_pkg: shared types and constants for the video-input front end.
// Holds the capture FSM encoding, pixel width and default frame geometry.
package vp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_CAPTURE = 2'd3
    } vp_state_e;

    localparam int RGB565_W   = 16;
    localparam int H_DISP_DEF = 1280;
    localparam int V_DISP_DEF = 720;

    function automatic logic [RGB565_W-1:0] rgb565_pack(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/dvp_frame_meter.sv
// dvp_frame_meter: saturating pixel/line counters for the DVP input.
// Latches line and frame size on vsync and keeps a sticky size error.
module dvp_frame_meter
    import vp_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF,
    parameter int V_DISP = V_DISP_DEF,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             check_en,
    input  logic             clr_err,
    input  logic             set_err,
    input  logic             vs_rise,
    input  logic             href_rise,
    input  logic             href_fall,
    input  logic             pix_done,
    output logic [CNT_W-1:0] meas_h,
    output logic [CNT_W-1:0] meas_v,
    output logic             size_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_DISP);

    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] meas_h_q, meas_h_d;
    logic [CNT_W-1:0] meas_v_q, meas_v_d;
    logic             size_err_q, size_err_d;
    logic             mismatch;

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        meas_h_d   = meas_h_q;
        meas_v_d   = meas_v_q;
        size_err_d = size_err_q;
        mismatch   = 1'b0;
        if (active) begin
            // vsync work happens before a coincident line start clears pix_cnt
            if (vs_rise) begin
                meas_h_d   = pix_cnt_q;
                meas_v_d   = line_cnt_q;
                line_cnt_d = '0;
                mismatch   = check_en &&
                             ((pix_cnt_q != H_EXP) || (line_cnt_q != V_EXP));
            end else if (href_fall && line_cnt_q != CNT_MAX) begin
                line_cnt_d = line_cnt_q + 1'b1;
            end
            if (href_rise) begin
                pix_cnt_d = '0;
            end else if (pix_done && pix_cnt_q != CNT_MAX) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
        if (clr_err) begin
            size_err_d = 1'b0;
        end else if (set_err || mismatch) begin
            size_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            meas_h_q   <= '0;
            meas_v_q   <= '0;
            size_err_q <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            meas_h_q   <= meas_h_d;
            meas_v_q   <= meas_v_d;
            size_err_q <= size_err_d;
        end
    end

    assign meas_h   = meas_h_q;
    assign meas_v   = meas_v_q;
    assign size_err = size_err_q;

endmodule

// File: rtl/dvp_capture.sv
// dvp_capture: DVP camera front end; packs byte pairs into RGB565 pixels.
// Drops settling frames after enable and reports measured frame geometry.
module dvp_capture
    import vp_pkg::*;
#(
    parameter int H_DISP     = H_DISP_DEF,
    parameter int V_DISP     = V_DISP_DEF,
    parameter int FRAME_SKIP = 10,
    parameter int CNT_W      = 12
) (
    input  logic                cam_pclk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [7:0]          cam_data,
    output logic                vi_clk,
    output logic                vi_vs,
    output logic                vi_de,
    output logic [RGB565_W-1:0] vi_data,
    output logic [15:0]         frame_cnt,
    output logic [CNT_W-1:0]    meas_h,
    output logic [CNT_W-1:0]    meas_v,
    output logic                size_err,
    output logic                capturing
);

    vp_state_e state_q, state_d;

    logic                vs_s1_q, href_s1_q;
    logic [7:0]          data_s1_q;
    logic                vs_prev_q, href_prev_q;
    logic [15:0]         skip_q, skip_d;
    logic                toggle_q, toggle_d;
    logic [7:0]          hi_q, hi_d;
    logic                vi_de_q, vi_de_d;
    logic                vi_vs_q, vi_vs_d;
    logic [RGB565_W-1:0] vi_data_q, vi_data_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic vs_rise, href_rise, href_fall;
    logic act, cap, pix_done, odd_err;

    assign vs_rise   = vs_s1_q & ~vs_prev_q;
    assign href_rise = href_s1_q & ~href_prev_q;
    assign href_fall = ~href_s1_q & href_prev_q;
    assign act       = (state_q != ST_IDLE);
    assign cap       = (state_q == ST_CAPTURE) & en;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SKIP;
                    skip_d  = 16'(FRAME_SKIP);
                end
                ST_SKIP: begin
                    if (skip_q == '0) begin
                        state_d = ST_WAIT_VS;
                    end else if (vs_rise) begin
                        skip_d = skip_q - 16'd1;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_rise) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: state_d = ST_CAPTURE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // byte phase also runs outside CAPTURE so skipped frames get measured
    always_comb begin
        toggle_d = 1'b0;
        hi_d     = hi_q;
        if (act && href_s1_q) begin
            toggle_d = ~toggle_q;
            if (!toggle_q) hi_d = data_s1_q;
        end
    end

    assign pix_done = act & href_s1_q & toggle_q;
    assign odd_err  = cap & href_fall & toggle_q;

    always_comb begin
        vi_de_d     = cap & pix_done;
        vi_vs_d     = cap & vs_s1_q;
        vi_data_d   = vi_data_q;
        frame_cnt_d = frame_cnt_q;
        if (vi_de_d) vi_data_d = rgb565_pack(hi_q, data_s1_q);
        if (cap && vs_rise) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge cam_pclk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vs_s1_q     <= 1'b0;
            href_s1_q   <= 1'b0;
            data_s1_q   <= '0;
            vs_prev_q   <= 1'b0;
            href_prev_q <= 1'b0;
            skip_q      <= '0;
            toggle_q    <= 1'b0;
            hi_q        <= '0;
            vi_de_q     <= 1'b0;
            vi_vs_q     <= 1'b0;
            vi_data_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vs_s1_q     <= cam_vsync;
            href_s1_q   <= cam_href;
            data_s1_q   <= cam_data;
            vs_prev_q   <= vs_s1_q;
            href_prev_q <= href_s1_q;
            skip_q      <= skip_d;
            toggle_q    <= toggle_d;
            hi_q        <= hi_d;
            vi_de_q     <= vi_de_d;
            vi_vs_q     <= vi_vs_d;
            vi_data_q   <= vi_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    dvp_frame_meter #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP),
        .CNT_W  (CNT_W)
    ) u_meter (
        .clk       (cam_pclk),
        .rst_n     (rst_n),
        .active    (act),
        .check_en  (state_q == ST_CAPTURE),
        .clr_err   (~en),
        .set_err   (odd_err),
        .vs_rise   (vs_rise),
        .href_rise (href_rise),
        .href_fall (href_fall),
        .pix_done  (pix_done),
        .meas_h    (meas_h),
        .meas_v    (meas_v),
        .size_err  (size_err)
    );

    assign vi_clk    = cam_pclk;
    assign vi_vs     = vi_vs_q;
    assign vi_de     = vi_de_q;
    assign vi_data   = vi_data_q;
    assign frame_cnt = frame_cnt_q;
    assign capturing = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_dvp_capture.sv
// tb_dvp_capture: directed bench for dvp_capture with an 8x4 frame
// geometry and two skipped frames.
module tb_dvp_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        vs = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        vi_clk, vi_vs, vi_de, size_err, capturing;
    logic [15:0] vi_data, frame_cnt;
    logic [11:0] meas_h, meas_v;

    int total = 0;
    int bad = 0;
    int de_cnt = 0;
    int vs_cnt = 0;

    always #5 clk = ~clk;

    dvp_capture #(
        .H_DISP     (8),
        .V_DISP     (4),
        .FRAME_SKIP (2),
        .CNT_W      (12)
    ) dut (
        .cam_pclk  (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cam_vsync (vs),
        .cam_href  (href),
        .cam_data  (data),
        .vi_clk    (vi_clk),
        .vi_vs     (vi_vs),
        .vi_de     (vi_de),
        .vi_data   (vi_data),
        .frame_cnt (frame_cnt),
        .meas_h    (meas_h),
        .meas_v    (meas_v),
        .size_err  (size_err),
        .capturing (capturing)
    );

    always @(negedge clk) begin
        if (vi_de === 1'b1) de_cnt++;
        if (vi_vs === 1'b1) vs_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vs_only();
        vs = 1'b1;
        tick(2);
        vs = 1'b0;
        tick(2);
    endtask

    task automatic send_line(input int nb);
        for (int b = 0; b < nb; b++) begin
            href = 1'b1;
            data = 8'(8'h10 + b);
            tick(1);
        end
        href = 1'b0;
        data = 8'h00;
        tick(3);
    endtask

    task automatic send_lines(input int nl, input int nb);
        for (int l = 0; l < nl; l++) send_line(nb);
    endtask

    task automatic send_frame(input int nl, input int nb);
        vs_only();
        send_lines(nl, nb);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        tick(3);
        @(negedge clk);
        total++;
        if ({vi_de, vi_vs, vi_data, frame_cnt, meas_h, meas_v,
             size_err, capturing} !== 60'd0) begin
            bad++;
            $display("FAIL reset_outs got de=%b vs=%b d=%h fc=%h h=%0d v=%0d e=%b c=%b",
                     vi_de, vi_vs, vi_data, frame_cnt, meas_h, meas_v,
                     size_err, capturing);
        end
        total++;
        if (vi_clk !== clk) begin
            bad++;
            $display("FAIL reset_viclk got %b exp %b", vi_clk, clk);
        end
    endtask

    task automatic test_skip();
        tick(1);
        rst_n = 1'b1;
        en = 1'b1;
        tick(1);
        de_cnt = 0;
        vs_cnt = 0;
        send_lines(2, 16);
        send_frame(4, 16);
        send_frame(4, 16);
        total++;
        if (de_cnt !== 0) begin
            bad++;
            $display("FAIL skip_no_de got %0d exp 0", de_cnt);
        end
        total++;
        if (vs_cnt !== 0) begin
            bad++;
            $display("FAIL skip_no_vs got %0d exp 0", vs_cnt);
        end
        total++;
        if (capturing !== 1'b0) begin
            bad++;
            $display("FAIL skip_not_cap got %b exp 0", capturing);
        end
        send_frame(4, 16);
        total++;
        if (capturing !== 1'b1) begin
            bad++;
            $display("FAIL skip_cap got %b exp 1", capturing);
        end
        de_cnt = 0;
        vs_cnt = 0;
        send_frame(4, 16);
        total++;
        if (de_cnt !== 32) begin
            bad++;
            $display("FAIL f4_strobes got %0d exp 32", de_cnt);
        end
        total++;
        if (vs_cnt !== 2) begin
            bad++;
            $display("FAIL f4_vi_vs got %0d exp 2", vs_cnt);
        end
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL f4_frame_cnt got %0d exp 1", frame_cnt);
        end
        total++;
        if (meas_h !== 12'd8 || meas_v !== 12'd4) begin
            bad++;
            $display("FAIL f4_meas got %0d x %0d exp 8 x 4", meas_h, meas_v);
        end
        total++;
        if (size_err !== 1'b0) begin
            bad++;
            $display("FAIL f4_size_err got %b exp 0", size_err);
        end
    endtask

    task automatic test_pixel();
        href = 1'b1;
        data = 8'hF8;
        tick(1);
        data = 8'h1F;
        tick(1);
        href = 1'b0;
        data = 8'h00;
        @(negedge clk);
        total++;
        if (vi_de !== 1'b0) begin
            bad++;
            $display("FAIL px_early got %b exp 0", vi_de);
        end
        @(negedge clk);
        total++;
        if (vi_de !== 1'b1 || vi_data !== 16'hF81F) begin
            bad++;
            $display("FAIL px_strobe got de=%b d=%h exp 1 F81F", vi_de, vi_data);
        end
        @(negedge clk);
        total++;
        if (vi_de !== 1'b0 || vi_data !== 16'hF81F) begin
            bad++;
            $display("FAIL px_hold got de=%b d=%h exp 0 F81F", vi_de, vi_data);
        end
        tick(2);
    endtask

    task automatic test_odd_line();
        de_cnt = 0;
        send_line(7);
        total++;
        if (de_cnt !== 3) begin
            bad++;
            $display("FAIL odd_strobes got %0d exp 3", de_cnt);
        end
        total++;
        if (vi_data !== 16'h1415) begin
            bad++;
            $display("FAIL odd_last_px got %h exp 1415", vi_data);
        end
        total++;
        if (size_err !== 1'b1) begin
            bad++;
            $display("FAIL odd_err got %b exp 1", size_err);
        end
        vs_only();
        total++;
        if (meas_h !== 12'd3) begin
            bad++;
            $display("FAIL odd_meas_h got %0d exp 3", meas_h);
        end
        total++;
        if (size_err !== 1'b1) begin
            bad++;
            $display("FAIL odd_err_sticky got %b exp 1", size_err);
        end
    endtask

    task automatic test_en_drop();
        href = 1'b1;
        data = 8'hAA;
        tick(1);
        data = 8'h55;
        tick(1);
        en = 1'b0;
        data = 8'h66;
        @(negedge clk);
        total++;
        if (capturing !== 1'b1) begin
            bad++;
            $display("FAIL drop_still_cap got %b exp 1", capturing);
        end
        @(negedge clk);
        total++;
        if ({vi_de, vi_vs, capturing} !== 3'b000) begin
            bad++;
            $display("FAIL drop_outs got de=%b vs=%b c=%b exp 0 0 0",
                     vi_de, vi_vs, capturing);
        end
        total++;
        if (size_err !== 1'b0) begin
            bad++;
            $display("FAIL drop_err_clr got %b exp 0", size_err);
        end
        tick(2);
        href = 1'b0;
        tick(3);
        en = 1'b1;
        tick(1);
        de_cnt = 0;
        send_frame(4, 16);
        send_frame(4, 16);
        total++;
        if (de_cnt !== 0 || capturing !== 1'b0) begin
            bad++;
            $display("FAIL restart_skip got de=%0d c=%b exp 0 0", de_cnt, capturing);
        end
        total++;
        if (size_err !== 1'b0) begin
            bad++;
            $display("FAIL restart_err got %b exp 0", size_err);
        end
        send_frame(5, 16);
        total++;
        if (capturing !== 1'b1) begin
            bad++;
            $display("FAIL restart_cap got %b exp 1", capturing);
        end
    endtask

    task automatic test_frame_size();
        vs_only();
        total++;
        if (meas_h !== 12'd8 || meas_v !== 12'd5) begin
            bad++;
            $display("FAIL tall_meas got %0d x %0d exp 8 x 5", meas_h, meas_v);
        end
        total++;
        if (size_err !== 1'b1) begin
            bad++;
            $display("FAIL tall_err got %b exp 1", size_err);
        end
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
        send_frame(4, 16);
        send_frame(4, 16);
        send_frame(4, 16);
        vs_only();
        total++;
        if (meas_h !== 12'd8 || meas_v !== 12'd4) begin
            bad++;
            $display("FAIL good_meas got %0d x %0d exp 8 x 4", meas_h, meas_v);
        end
        total++;
        if (size_err !== 1'b0) begin
            bad++;
            $display("FAIL good_err got %b exp 0", size_err);
        end
    endtask

    task automatic test_wrap_reset();
        send_lines(4, 16);
        force dut.frame_cnt_q = 16'hFFFF;
        tick(1);
        release dut.frame_cnt_q;
        @(negedge clk);
        total++;
        if (frame_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_preload got %h exp FFFF", frame_cnt);
        end
        tick(1);
        vs_only();
        total++;
        if (frame_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero got %h exp 0000", frame_cnt);
        end
        href = 1'b1;
        data = 8'h12;
        tick(1);
        data = 8'h34;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({vi_de, vi_vs, vi_data, frame_cnt, meas_h, meas_v,
             size_err, capturing} !== 60'd0) begin
            bad++;
            $display("FAIL rst_mid_outs got de=%b d=%h fc=%h h=%0d v=%0d e=%b c=%b",
                     vi_de, vi_data, frame_cnt, meas_h, meas_v, size_err, capturing);
        end
        de_cnt = 0;
        data = 8'h56;
        tick(4);
        href = 1'b0;
        tick(3);
        total++;
        if (de_cnt !== 0) begin
            bad++;
            $display("FAIL rst_mid_no_de got %0d exp 0", de_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_pixel();
        test_odd_line();
        test_en_drop();
        test_frame_size();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
